// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter.
// Contents:
//   arb_state_t     - arbiter FSM states (IDLE, GRANT, RESP)
//   owner_t         - which requester owns the current access (OWN_I, OWN_D)
//   SZ_B/SZ_H/SZ_W  - store size codes as seen on d_w_size / mem_w_size
//   pick_data_port  - round-robin winner selection
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // A lone requester always wins. On a tie, the port that did not win
    // last time wins, so a tie straight after reset goes to the data port.
    function automatic logic pick_data_port(input logic   i_req,
                                            input logic   d_req,
                                            input owner_t last_grant);
        return d_req && (!i_req || (last_grant == OWN_I));
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
// Counts cycles spent waiting on the memory and flags when the wait limit
// has been used up.
// Ports:
//   clk      - clock, posedge
//   reset    - synchronous active-high reset
//   clear    - zero the counter (held while no access is outstanding)
//   count_en - an access is outstanding; count this cycle
//   expired  - the current cycle is the last one allowed for the access
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    // Saturating wait counter. It holds the number of outstanding cycles
    // already survived, so it reads TIMEOUT on the (TIMEOUT+1)-th cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count_en && (count != LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = count_en && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Lets the instruction-fetch port and the data port of minuteCore share one
// memory. Requests are captured into registers on grant, ties are resolved
// round-robin, and a watchdog aborts accesses the memory never answers.
// Ports:
//   clk, reset                      - clock and synchronous active-high reset
//   i_addr, i_enable                - fetch request (held until i_ready)
//   i_data, i_ready                 - fetch data and one-cycle completion pulse
//   d_addr, d_r_enable, d_w_enable  - data request (write wins if both high)
//   d_w_size, d_w_data              - store size code and store data
//   d_r_data, d_ready               - load data and one-cycle completion pulse
//   mem_addr, mem_r_enable,
//   mem_w_enable, mem_w_size,
//   mem_w_data                      - request towards the memory
//   mem_r_data, mem_ready           - memory response
//   bus_error                       - one-cycle pulse on an aborted access
//   busy                            - arbiter is not idle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_enable,
    output logic [DATA_W-1:0] i_data,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_r_enable,
    input  logic              d_w_enable,
    input  logic [1:0]        d_w_size,
    input  logic [DATA_W-1:0] d_w_data,
    output logic [DATA_W-1:0] d_r_data,
    output logic              d_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_r_enable,
    output logic              mem_w_enable,
    output logic [1:0]        mem_w_size,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data,
    input  logic              mem_ready,
    output logic              bus_error,
    output logic              busy
);

    arb_state_t state;
    // Last port granted; while an access is outstanding it is also the owner.
    owner_t     last_grant;
    logic       i_req;
    logic       d_req;
    logic       grant_d;
    logic       in_grant;
    logic       expired;

    assign i_req    = i_enable;
    assign d_req    = d_r_enable | d_w_enable;
    assign grant_d  = pick_data_port(i_req, d_req, last_grant);
    assign in_grant = (state == ST_GRANT);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (!in_grant),
        .count_en (in_grant),
        .expired  (expired)
    );

    // Arbiter FSM with every output registered. The memory side is driven
    // only from what was captured at grant time, so requester inputs can
    // change freely while an access is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= OWN_I;
            i_data       <= '0;
            i_ready      <= 1'b0;
            d_r_data     <= '0;
            d_ready      <= 1'b0;
            mem_addr     <= '0;
            mem_r_enable <= 1'b0;
            mem_w_enable <= 1'b0;
            mem_w_size   <= SZ_B;
            mem_w_data   <= '0;
            bus_error    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            bus_error <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        state <= ST_GRANT;
                        busy  <= 1'b1;
                        if (grant_d) begin
                            last_grant   <= OWN_D;
                            mem_addr     <= d_addr;
                            mem_r_enable <= !d_w_enable;
                            mem_w_enable <= d_w_enable;
                            mem_w_size   <= d_w_size;
                            mem_w_data   <= d_w_data;
                        end else begin
                            // Fetches are always reads with no store payload.
                            last_grant   <= OWN_I;
                            mem_addr     <= i_addr;
                            mem_r_enable <= 1'b1;
                            mem_w_enable <= 1'b0;
                            mem_w_size   <= SZ_B;
                            mem_w_data   <= '0;
                        end
                    end
                end

                ST_GRANT: begin
                    // A memory answer in the watchdog's last cycle still counts.
                    if (mem_ready || expired) begin
                        state        <= ST_RESP;
                        mem_r_enable <= 1'b0;
                        mem_w_enable <= 1'b0;
                        bus_error    <= !mem_ready;
                        if (last_grant == OWN_D) begin
                            d_ready  <= 1'b1;
                            d_r_data <= mem_ready ? mem_r_data : '0;
                        end else begin
                            i_ready  <= 1'b1;
                            i_data   <= mem_ready ? mem_r_data : '0;
                        end
                    end
                end

                ST_RESP: begin
                    // Always pass through IDLE so a still-high enable from
                    // the owner is not mistaken for a new request.
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    mem_r_enable <= 1'b0;
                    mem_w_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (TIMEOUT = 4). A transaction-level
// reference model predicts every registered output each cycle; directed
// scenarios add literal expectations, then a randomized phase runs both
// ports against a memory with random latency, including no answer at all.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] i_addr;
    logic          i_enable;
    logic [DW-1:0] i_data;
    logic          i_ready;
    logic [AW-1:0] d_addr;
    logic          d_r_enable;
    logic          d_w_enable;
    logic [1:0]    d_w_size;
    logic [DW-1:0] d_w_data;
    logic [DW-1:0] d_r_data;
    logic          d_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_r_enable;
    logic          mem_w_enable;
    logic [1:0]    mem_w_size;
    logic [DW-1:0] mem_w_data;
    logic [DW-1:0] mem_r_data;
    logic          mem_ready;
    logic          bus_error;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_addr       (i_addr),
        .i_enable     (i_enable),
        .i_data       (i_data),
        .i_ready      (i_ready),
        .d_addr       (d_addr),
        .d_r_enable   (d_r_enable),
        .d_w_enable   (d_w_enable),
        .d_w_size     (d_w_size),
        .d_w_data     (d_w_data),
        .d_r_data     (d_r_data),
        .d_ready      (d_ready),
        .mem_addr     (mem_addr),
        .mem_r_enable (mem_r_enable),
        .mem_w_enable (mem_w_enable),
        .mem_w_size   (mem_w_size),
        .mem_w_data   (mem_w_data),
        .mem_r_data   (mem_r_data),
        .mem_ready    (mem_ready),
        .bus_error    (bus_error),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Memory responder: answers after a chosen number of enabled cycles
    // (0 = never answers); read data is random junk outside the answer cycle.
    int          rsp_latency = 1;
    logic [31:0] rsp_data    = '0;
    bit          rand_lat    = 1'b0;
    int          en_cycles   = 0;
    int          cur_lat     = 0;

    initial begin
        mem_ready  = 1'b0;
        mem_r_data = '0;
    end

    always @(negedge clk) begin
        if (mem_r_enable || mem_w_enable) begin
            if (en_cycles == 0)
                cur_lat = rand_lat ? int'($urandom_range(0, 6)) : rsp_latency;
            en_cycles++;
            mem_ready  = (cur_lat != 0) && (en_cycles == cur_lat);
            mem_r_data = mem_ready ? (rand_lat ? $urandom : rsp_data) : $urandom;
        end else begin
            en_cycles  = 0;
            mem_ready  = 1'b0;
            mem_r_data = $urandom;
        end
    end

    // Reference model, transaction view: an access is either waiting on the
    // memory (counting how many cycles its strobe has been up), or being
    // reported back to its owner for one cycle, or nothing is in flight.
    bit          m_waiting = 0, m_reporting = 0, m_own_d = 0, m_last_d = 0;
    bit          m_is_write = 0, m_dknown = 1;
    int          m_up_cycles = 0;
    logic [31:0] e_i_data = '0, e_d_data = '0, e_addr = '0, e_wdata = '0;
    logic [1:0]  e_size = '0;
    bit          e_ir = 0, e_dr = 0, e_err = 0, e_busy = 0, e_mr = 0, e_mw = 0;

    always @(posedge clk) begin
        bit want_i, want_d, gave_up;
        if (reset) begin
            m_waiting = 0; m_reporting = 0; m_last_d = 0; m_dknown = 1;
            e_i_data = '0; e_d_data = '0; e_addr = '0; e_wdata = '0; e_size = '0;
            e_ir = 0; e_dr = 0; e_err = 0; e_busy = 0; e_mr = 0; e_mw = 0;
        end else begin
            e_ir = 0; e_dr = 0; e_err = 0;
            if (m_reporting) begin
                m_reporting = 0;
                e_busy = 0;
            end else if (m_waiting) begin
                m_up_cycles++;
                gave_up = !mem_ready && (m_up_cycles > TO);
                if (mem_ready || gave_up) begin
                    m_waiting = 0; m_reporting = 1;
                    e_mr = 0; e_mw = 0; e_err = gave_up;
                    if (m_own_d) begin
                        e_dr = 1;
                        if (gave_up) begin e_d_data = '0; m_dknown = 1; end
                        else if (m_is_write) m_dknown = 0;
                        else begin e_d_data = mem_r_data; m_dknown = 1; end
                    end else begin
                        e_ir = 1;
                        e_i_data = gave_up ? 32'h0 : mem_r_data;
                    end
                end
            end else begin
                want_i = i_enable;
                want_d = d_r_enable | d_w_enable;
                if (want_i || want_d) begin
                    m_own_d = want_d && !(want_i && m_last_d);
                    m_last_d = m_own_d;
                    m_waiting = 1; m_up_cycles = 0; e_busy = 1;
                    if (m_own_d) begin
                        m_is_write = d_w_enable;
                        e_addr = d_addr; e_mw = d_w_enable; e_mr = !d_w_enable;
                        e_size = d_w_size; e_wdata = d_w_data;
                    end else begin
                        m_is_write = 0;
                        e_addr = i_addr; e_mr = 1; e_mw = 0; e_size = '0; e_wdata = '0;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("i_ready", 32'(i_ready), 32'(e_ir));
            checkOutput("d_ready", 32'(d_ready), 32'(e_dr));
            checkOutput("bus_error", 32'(bus_error), 32'(e_err));
            checkOutput("busy", 32'(busy), 32'(e_busy));
            checkOutput("mem_r_enable", 32'(mem_r_enable), 32'(e_mr));
            checkOutput("mem_w_enable", 32'(mem_w_enable), 32'(e_mw));
            checkOutput("mem_en_excl", 32'(mem_r_enable & mem_w_enable), 32'h0);
            checkOutput("i_data", i_data, e_i_data);
            if (m_dknown) checkOutput("d_r_data", d_r_data, e_d_data);
            if (e_mr || e_mw) begin
                checkOutput("mem_addr", mem_addr, e_addr);
                checkOutput("mem_w_size", 32'(mem_w_size), 32'(e_size));
                checkOutput("mem_w_data", mem_w_data, e_wdata);
            end
        end
    end

    // Per-transaction observations gathered by applyStimulus.
    int          st_en_cycles, st_rise_to_ready, st_ready_cnt, st_other_ready;
    int          st_r_cycles, st_w_cycles;
    bit          st_err_with_ready, st_stable_ok, st_busy_after;
    logic [31:0] st_first_addr, st_first_wdata, st_rdata;
    logic [1:0]  st_first_size;

    task automatic applyStimulus(input bit to_d, input logic [31:0] addr,
                                 input bit rd, input bit wr, input logic [1:0] sz,
                                 input logic [31:0] wdata, input int lat,
                                 input logic [31:0] rdata);
        int  cyc, rise_cyc;
        bit  done, started;
        rsp_latency = lat;
        rsp_data    = rdata;
        if (to_d) begin
            d_addr = addr; d_r_enable = rd; d_w_enable = wr;
            d_w_size = sz; d_w_data = wdata;
        end else begin
            i_addr = addr; i_enable = 1'b1;
        end
        st_en_cycles = 0; st_rise_to_ready = -1; st_ready_cnt = 0; st_other_ready = 0;
        st_r_cycles = 0; st_w_cycles = 0; st_err_with_ready = 0; st_stable_ok = 1;
        st_first_addr = '0; st_first_wdata = '0; st_first_size = '0; st_rdata = '0;
        done = 0; started = 0; cyc = 0; rise_cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_r_enable || mem_w_enable) begin
                st_en_cycles++;
                if (mem_r_enable) st_r_cycles++;
                if (mem_w_enable) st_w_cycles++;
                if (!started) begin
                    started = 1; rise_cyc = cyc;
                    st_first_addr = mem_addr; st_first_wdata = mem_w_data;
                    st_first_size = mem_w_size;
                end else if (mem_addr !== st_first_addr || mem_w_data !== st_first_wdata ||
                             mem_w_size !== st_first_size) begin
                    st_stable_ok = 0;
                end
            end
            if (to_d ? i_ready : d_ready) st_other_ready++;
            if (to_d ? d_ready : i_ready) begin
                done = 1;
                st_ready_cnt++;
                st_rise_to_ready  = cyc - rise_cyc;
                st_err_with_ready = bus_error;
                st_rdata          = to_d ? d_r_data : i_data;
            end
        end
        i_enable = 1'b0; d_r_enable = 1'b0; d_w_enable = 1'b0;
        if (!done) checkOutput("handshake_bound", 32'h0, 32'h1);
        @(negedge clk);
        if (to_d ? d_ready : i_ready) st_ready_cnt++;
        st_busy_after = busy;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] grant_addr [4];
    int          n_grants;
    bit          prev_en;
    int          stray;
    bit          saw_grant;
    int          op;

    initial begin
        reset = 1'b1;
        i_addr = '0; i_enable = 1'b0;
        d_addr = '0; d_r_enable = 1'b0; d_w_enable = 1'b0;
        d_w_size = '0; d_w_data = '0;
        repeat (2) @(negedge clk);

        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_i_ready", 32'(i_ready), 32'h0);
        checkOutput("reset_mem_r_enable", 32'(mem_r_enable), 32'h0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        reset  = 1'b0;
        cmp_on = 1'b1;

        // Single fetch, memory answers in its second cycle.
        applyStimulus(1'b0, 32'h10, 1'b1, 1'b0, 2'b00, 32'h0, 2, 32'h0050_0093);
        checkOutput("fetch_addr", st_first_addr, 32'h10);
        checkOutput("fetch_r_cycles", 32'(st_r_cycles), 32'd2);
        checkOutput("fetch_latency", 32'(st_rise_to_ready), 32'd2);
        checkOutput("fetch_data", st_rdata, 32'h0050_0093);
        checkOutput("fetch_ready_cnt", 32'(st_ready_cnt), 32'd1);
        checkOutput("fetch_d_ready", 32'(st_other_ready), 32'd0);
        checkOutput("fetch_idle_after", 32'(st_busy_after), 32'h0);

        // Tie straight after reset: D first, then strict alternation.
        pulseReset();
        rsp_latency = 1; rsp_data = 32'h0000_CAFE;
        foreach (grant_addr[k]) grant_addr[k] = '0;
        i_addr = 32'h20; i_enable = 1'b1;
        d_addr = 32'h100; d_r_enable = 1'b1;
        n_grants = 0; prev_en = 0;
        for (int c = 0; c < 40 && n_grants < 4; c++) begin
            @(negedge clk);
            if (mem_r_enable && !prev_en) begin
                grant_addr[n_grants] = mem_addr;
                n_grants++;
            end
            prev_en = mem_r_enable;
        end
        i_enable = 1'b0; d_r_enable = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("tie_grant0", grant_addr[0], 32'h100);
        checkOutput("tie_grant1", grant_addr[1], 32'h20);
        checkOutput("tie_grant2", grant_addr[2], 32'h100);
        checkOutput("tie_grant3", grant_addr[3], 32'h20);

        // Byte store held until the memory answers.
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b1, 2'b00, 32'hAB, 3, 32'h5555_AAAA);
        checkOutput("store_addr", st_first_addr, 32'h104);
        checkOutput("store_w_cycles", 32'(st_w_cycles), 32'd3);
        checkOutput("store_r_cycles", 32'(st_r_cycles), 32'd0);
        checkOutput("store_size", 32'(st_first_size), 32'h0);
        checkOutput("store_wdata", st_first_wdata, 32'hAB);
        checkOutput("store_stable", 32'(st_stable_ok), 32'h1);
        checkOutput("store_ready_cnt", 32'(st_ready_cnt), 32'd1);

        // Read and write enables together issue a write.
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b1, 2'b10, 32'h1234_5678, 1, 32'h0);
        checkOutput("both_w_cycles", 32'(st_w_cycles), 32'd1);
        checkOutput("both_r_cycles", 32'(st_r_cycles), 32'd0);
        checkOutput("both_wdata", st_first_wdata, 32'h1234_5678);
        checkOutput("both_size", 32'(st_first_size), 32'h2);

        // Memory never answers: abort TIMEOUT+1 cycles after the strobe rose.
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 2'b00, 32'h0, 0, 32'h0);
        checkOutput("timeout_latency", 32'(st_rise_to_ready), 32'd5);
        checkOutput("timeout_bus_error", 32'(st_err_with_ready), 32'h1);
        checkOutput("timeout_rdata", st_rdata, 32'h0);
        checkOutput("timeout_ready_cnt", 32'(st_ready_cnt), 32'd1);
        checkOutput("timeout_idle_after", 32'(st_busy_after), 32'h0);

        // Reset while an access is outstanding.
        rsp_latency = 0;
        i_addr = 32'h30; i_enable = 1'b1;
        saw_grant = 0;
        for (int c = 0; c < 10 && !saw_grant; c++) begin
            @(negedge clk);
            if (mem_r_enable) saw_grant = 1;
        end
        checkOutput("rst_grant_seen", 32'(saw_grant), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; i_enable = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_mem_r_enable", 32'(mem_r_enable), 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_i_ready", 32'(i_ready), 32'h0);
        checkOutput("rst_bus_error", 32'(bus_error), 32'h0);
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (i_ready || d_ready || bus_error) stray++;
        end
        checkOutput("rst_no_pulse", 32'(stray), 32'd0);
        applyStimulus(1'b0, 32'h40, 1'b1, 1'b0, 2'b00, 32'h0, 1, 32'hDEAD_BEEF);
        checkOutput("rst_refetch_data", st_rdata, 32'hDEAD_BEEF);
        checkOutput("rst_refetch_ready", 32'(st_ready_cnt), 32'd1);

        // Randomized traffic on both ports, random latency, rare resets.
        rand_lat = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;

            if (i_ready || (i_enable && $urandom_range(0, 15) == 0)) begin
                i_enable = 1'b0;
            end else if (!i_enable && $urandom_range(0, 1) == 1) begin
                i_enable = 1'b1;
                i_addr   = $urandom;
            end

            if (d_ready || ((d_r_enable || d_w_enable) && $urandom_range(0, 15) == 0)) begin
                d_r_enable = 1'b0;
                d_w_enable = 1'b0;
            end else if (!(d_r_enable || d_w_enable) && $urandom_range(0, 1) == 1) begin
                op         = int'($urandom_range(0, 3));
                d_r_enable = (op != 1);
                d_w_enable = (op == 1) || (op == 2);
                d_addr     = $urandom;
                d_w_size   = 2'($urandom_range(0, 3));
                d_w_data   = $urandom;
            end
        end
        reset = 1'b0;
        i_enable = 1'b0; d_r_enable = 1'b0; d_w_enable = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
